// File: rtl/bench_output_capture_uart_if.sv
// Capture/UART bus interface.
// Groups the benchmark-side capture inputs and the serial/status outputs of
// bench_output_capture_uart so they travel as one port.
//   sample_in  : byte from the benchmark wrapper output
//   capture_en : push request qualifier
//   clear      : synchronous flush of FIFO, overflow flag and change history
//   tx         : UART 8N1 serial line, idle high
//   busy       : high while a frame is on tx
//   fifo_count : entries currently held in the FIFO
//   overflow   : sticky "a push was dropped" flag
// Modports: master drives the capture side, slave is the capture/UART block.
interface bench_output_capture_uart_if #(
    parameter int DEPTH = 8
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    sample_in;
    logic          capture_en;
    logic          clear;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output sample_in, capture_en, clear,
        input  tx, busy, fifo_count, overflow
    );

    modport slave (
        input  sample_in, capture_en, clear,
        output tx, busy, fifo_count, overflow
    );
endinterface

// File: rtl/bench_output_capture_uart.sv
// Benchmark output capture with UART streaming.
// Samples the benchmark output byte into a small FIFO (optionally only when
// the value changes) and sends each byte, oldest first, as a UART 8N1 frame.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset, aborts any frame in progress
//   bus   : slave side of bench_output_capture_uart_if
//           (sample_in, capture_en, clear in; tx, busy, fifo_count, overflow out)
module bench_output_capture_uart #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int CHANGE_ONLY  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    bench_output_capture_uart_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO state
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    last_q, last_d;
    logic          last_valid_q, last_valid_d;

    // Transmitter state
    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [BW-1:0] baud_q, baud_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    logic          push_req_s;
    logic          accept_s;
    logic          pop_s;
    logic          baud_done_s;

    // Transmit FSM: next state, registered tx/busy values and FIFO pop request
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        baud_d      = baud_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        pop_s       = 1'b0;
        baud_done_s = (baud_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                // clear blocks the pop so a flushed FIFO never starts a frame
                if ((count_q != CNT_ZERO) && !bus.clear) begin
                    pop_s     = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = 3'd0;
                    baud_d    = BAUD_ZERO;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_done_s) begin
                    baud_d  = BAUD_ZERO;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_done_s) begin
                    baud_d = BAUD_ZERO;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // present the next bit while shifting it into place
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_done_s) begin
                    baud_d  = BAUD_ZERO;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                baud_d  = BAUD_ZERO;
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO: push qualification, storage, pointers, count and sticky overflow
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        last_d       = last_q;
        last_valid_d = last_valid_q;

        push_req_s = bus.capture_en && !bus.clear &&
                     ((CHANGE_ONLY == 0) || !last_valid_q || (bus.sample_in != last_q));
        // fullness is judged on the pre-edge count, so a same-edge pop does not make room
        accept_s   = push_req_s && (count_q < DEPTH_C);

        if (bus.clear) begin
            wr_ptr_d     = PTR_ZERO;
            rd_ptr_d     = PTR_ZERO;
            count_d      = CNT_ZERO;
            overflow_d   = 1'b0;
            last_valid_d = 1'b0;
        end else begin
            if (accept_s) begin
                mem_d[wr_ptr_q] = bus.sample_in;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
                last_d          = bus.sample_in;
                last_valid_d    = 1'b1;
            end else if (push_req_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            if (accept_s && !pop_s) begin
                count_d = count_q + CNT_ONE;
            end else if (!accept_s && pop_s) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end
        end
    end

    // State registers for FIFO and transmitter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q     <= PTR_ZERO;
            rd_ptr_q     <= PTR_ZERO;
            count_q      <= CNT_ZERO;
            overflow_q   <= 1'b0;
            last_q       <= 8'h00;
            last_valid_q <= 1'b0;
            state_q      <= S_IDLE;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            baud_q       <= BAUD_ZERO;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            baud_q       <= baud_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_bench_output_capture_uart.sv
module tb_bench_output_capture_uart;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;

    // u_dut0 filters repeats, u_dut1 captures every enabled cycle
    bench_output_capture_uart_if #(.DEPTH(8)) if0 ();
    bench_output_capture_uart_if #(.DEPTH(8)) if1 ();

    bench_output_capture_uart #(.DEPTH(8), .CLKS_PER_BIT(4), .CHANGE_ONLY(1)) u_dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    bench_output_capture_uart #(.DEPTH(8), .CLKS_PER_BIT(4), .CHANGE_ONLY(0)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );

    // scoreboards: bytes expected on each tx line, and observed frame start cycles
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         start_q0[$];

    // serial receiver state per DUT
    bit         rx_act [2];
    int         rx_k   [2];
    logic [7:0] rx_sh  [2];
    logic       prev_tx[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one negedge step of the UART receiver; compares each finished byte with the scoreboard
    task automatic rx_step(input int idx, input logic txv, input logic busyv);
        logic [7:0] e;
        int         n;
        if (reset) begin
            rx_act[idx]  = 1'b0;
            prev_tx[idx] = 1'b1;
        end else if (!rx_act[idx]) begin
            if (prev_tx[idx] === 1'b1 && txv === 1'b0) begin
                rx_act[idx] = 1'b1;
                rx_k[idx]   = 0;
                if (idx == 0) start_q0.push_back(cyc);
                chk("rx_busy_at_start", {31'd0, busyv}, 32'd1);
            end
            prev_tx[idx] = txv;
        end else begin
            rx_k[idx]++;
            if (rx_k[idx] == 2) chk("rx_start_bit", {31'd0, txv}, 32'd0);
            if (rx_k[idx] >= 5 && rx_k[idx] <= 33 && ((rx_k[idx] - 5) % 4) == 0)
                rx_sh[idx][(rx_k[idx] - 5) / 4] = txv;
            if (rx_k[idx] == 37) begin
                chk("rx_stop_bit", {31'd0, txv}, 32'd1);
                chk("rx_busy_in_stop", {31'd0, busyv}, 32'd1);
                n = (idx == 0) ? exp_q0.size() : exp_q1.size();
                chk("rx_byte_was_expected", {31'd0, (n > 0)}, 32'd1);
                if (n > 0) begin
                    e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk($sformatf("rx_byte_dut%0d", idx), {24'd0, rx_sh[idx]}, {24'd0, e});
                end
                rx_act[idx] = 1'b0;
            end
            prev_tx[idx] = txv;
        end
    endtask

    always @(negedge clk) begin
        rx_step(0, if0.tx, if0.busy);
        rx_step(1, if1.tx, if1.busy);
    end

    // wait until a DUT has sent all expected bytes and gone idle, counting busy cycles
    task automatic wait_idle(input int idx, input int budget, output int busy_cycles);
        int  n;
        bit  done;
        done        = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (idx == 0) begin
                if (if0.busy) busy_cycles++;
                n    = exp_q0.size();
                done = (n == 0) && !if0.busy;
            end else begin
                if (if1.busy) busy_cycles++;
                n    = exp_q1.size();
                done = (n == 0) && !if1.busy;
            end
        end
        chk($sformatf("drain_dut%0d_in_time", idx), {31'd0, done}, 32'd1);
    endtask

    initial begin
        int bc;
        total = 0;
        bad   = 0;
        cyc   = 0;
        for (int i = 0; i < 2; i++) begin
            rx_act[i]  = 1'b0;
            rx_k[i]    = 0;
            rx_sh[i]   = 8'h00;
            prev_tx[i] = 1'b1;
        end
        reset = 1'b1;
        if0.sample_in = 8'h00; if0.capture_en = 1'b0; if0.clear = 1'b0;
        if1.sample_in = 8'h00; if1.capture_en = 1'b0; if1.clear = 1'b0;
        tick();
        tick();
        chk("reset_tx", {31'd0, if0.tx}, 32'd1);
        chk("reset_busy", {31'd0, if0.busy}, 32'd0);
        chk("reset_count", {28'd0, if0.fifo_count}, 32'd0);
        chk("reset_overflow", {31'd0, if0.overflow}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: single byte 0xA5, latency and frame length
        if0.sample_in = 8'hA5; if0.capture_en = 1'b1; exp_q0.push_back(8'hA5);
        tick();
        if0.capture_en = 1'b0;
        chk("t1_count_after_push", {28'd0, if0.fifo_count}, 32'd1);
        chk("t1_tx_idle_at_push", {31'd0, if0.tx}, 32'd1);
        tick();
        chk("t1_tx_low_after_pop", {31'd0, if0.tx}, 32'd0);
        chk("t1_busy_after_pop", {31'd0, if0.busy}, 32'd1);
        chk("t1_count_after_pop", {28'd0, if0.fifo_count}, 32'd0);
        wait_idle(0, 200, bc);
        chk("t1_frame_cycles", bc + 1, 32'd40);

        // 2: a held value is captured once; a changed value is captured again
        if0.sample_in = 8'h3C; if0.capture_en = 1'b1; exp_q0.push_back(8'h3C);
        for (int i = 0; i < 20; i++) tick();
        chk("t2_count_after_hold", {28'd0, if0.fifo_count}, 32'd0);
        if0.sample_in = 8'h3D; exp_q0.push_back(8'h3D);
        tick();
        chk("t2_count_after_change", {28'd0, if0.fifo_count}, 32'd1);
        if0.capture_en = 1'b0;
        wait_idle(0, 300, bc);
        chk("t2_overflow", {31'd0, if0.overflow}, 32'd0);

        // 3: capture every cycle into a FIFO with no room to drain
        if1.capture_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if1.sample_in = 8'h10 + 8'(i);
            if (i < 9) exp_q1.push_back(8'h10 + 8'(i));
            tick();
        end
        if1.capture_en = 1'b0;
        chk("t3_count_saturated", {28'd0, if1.fifo_count}, 32'd8);
        chk("t3_overflow", {31'd0, if1.overflow}, 32'd1);
        wait_idle(1, 600, bc);
        chk("t3_count_drained", {28'd0, if1.fifo_count}, 32'd0);

        // 4: three back-to-back pushes, frames start 41 cycles apart
        start_q0.delete();
        if0.capture_en = 1'b1;
        if0.sample_in = 8'h11; exp_q0.push_back(8'h11); tick();
        if0.sample_in = 8'h22; exp_q0.push_back(8'h22); tick();
        if0.sample_in = 8'h33; exp_q0.push_back(8'h33); tick();
        if0.capture_en = 1'b0;
        wait_idle(0, 300, bc);
        chk("t4_frames_seen", start_q0.size(), 32'd3);
        if (start_q0.size() == 3) begin
            chk("t4_gap_1_2", start_q0[1] - start_q0[0], 32'd41);
            chk("t4_gap_2_3", start_q0[2] - start_q0[1], 32'd41);
        end

        // 5: fill to overflow during a frame, then clear mid-frame
        if0.capture_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if0.sample_in = 8'h51 + 8'(i);
            tick();
        end
        exp_q0.push_back(8'h51);
        if0.capture_en = 1'b0;
        chk("t5_count_full", {28'd0, if0.fifo_count}, 32'd8);
        chk("t5_overflow_set", {31'd0, if0.overflow}, 32'd1);
        if0.clear = 1'b1;
        tick();
        if0.clear = 1'b0;
        chk("t5_count_cleared", {28'd0, if0.fifo_count}, 32'd0);
        chk("t5_overflow_cleared", {31'd0, if0.overflow}, 32'd0);
        chk("t5_frame_continues", {31'd0, if0.busy}, 32'd1);
        wait_idle(0, 200, bc);
        chk("t5_tx_idle", {31'd0, if0.tx}, 32'd1);
        // 0x59 was the last accepted byte; it is accepted again after clear
        if0.sample_in = 8'h59; if0.capture_en = 1'b1; exp_q0.push_back(8'h59);
        tick();
        if0.capture_en = 1'b0;
        chk("t5_repush_accepted", {28'd0, if0.fifo_count}, 32'd1);
        wait_idle(0, 200, bc);

        // 6: asynchronous reset while DATA bit 3 is on the line
        if0.capture_en = 1'b1;
        if0.sample_in = 8'h96; tick();
        if0.sample_in = 8'h69; tick();
        if0.capture_en = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("t6_busy_before_reset", {31'd0, if0.busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_tx_async", {31'd0, if0.tx}, 32'd1);
        chk("t6_busy_async", {31'd0, if0.busy}, 32'd0);
        chk("t6_count_async", {28'd0, if0.fifo_count}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        if0.sample_in = 8'hC3; if0.capture_en = 1'b1; exp_q0.push_back(8'hC3);
        tick();
        if0.capture_en = 1'b0;
        wait_idle(0, 200, bc);
        chk("t6_frame_cycles", bc, 32'd40);
        chk("end_dut1_queue_empty", exp_q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
